vdp_super_res_writer: RTL and testbench
=======================================

VDP_SUPER_RES_WRITER -- requirements
Module: vdp_super_res_writer

Interface
REQ-001 SHALL have ports as listed; one clock `clk`; `reset` is synchronous, active-high.
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- vdp_super  in  1  super-res mode enable; low = writer held idle and flushed
- super_res_drawing  in  1  display reader owns VRAM this cycle; no new write issued
- cpu_wr  in  1  one-cycle CPU port write strobe
- cpu_port  in  2  0 = data, 1 = addr[7:0], 2 = addr[15:8], 3 = addr[18:16]
- cpu_data  in  8  CPU write byte
- vram_ack  in  1  one-cycle completion of the issued VRAM write
- writer_vram_addr  out  17  32-bit word address
- writer_vram_wdata  out  32  write data, byte lanes per writer_vram_be
- writer_vram_be  out  4  byte enables; bit i = bits [8i+7:8i]
- writer_vram_wr  out  1  write request, level, held until vram_ack
- writer_busy  out  1  FIFO non-empty or transaction outstanding
- writer_overflow  out  1  sticky: a data byte was dropped

Function
REQ-002 SHALL keep a 19-bit byte address register `wr_addr`; port 1/2/3 writes load the named bits; bits [7:3] of cpu_data on port 3 are ignored.
REQ-003 SHALL push {wr_addr, cpu_data} into a 4-entry FIFO on every port-0 write when not full, then increment wr_addr by 1 modulo 2^19 (7FFFF -> 00000).
REQ-004 SHALL evaluate full from the pre-edge count: a port-0 write while full is dropped, does not increment wr_addr, and sets writer_overflow, even when a pop occurs in the same cycle.
REQ-005 SHALL clear writer_overflow on any address-port write; set takes priority if both occur in one cycle (impossible by single strobe, stated for completeness).
REQ-006 An address-port write SHALL NOT alter queued entries; each entry keeps its captured address.
REQ-007 SHALL implement state machine IDLE, WAIT_ACK.
- IDLE: if FIFO non-empty and super_res_drawing = 0: register addr = entry[18:2], be = one-hot of entry[1:0], wdata = byte replicated in all four lanes, assert writer_vram_wr, pop entry, go to WAIT_ACK.
- WAIT_ACK: hold all writer_vram_* outputs stable; on vram_ack deassert writer_vram_wr and return to IDLE.
REQ-008 super_res_drawing rising during WAIT_ACK SHALL NOT drop or alter the outstanding request.
REQ-009 Latency: cpu_wr sampled on edge N into an empty FIFO with super_res_drawing low SHALL give writer_vram_wr high after edge N+1.
REQ-010 After vram_ack at edge M, the next request SHALL be asserted no earlier than after edge M+1 (one idle cycle minimum).
REQ-011 writer_busy SHALL be high whenever FIFO count > 0 or state = WAIT_ACK, registered with the state.
REQ-012 Push and pop in the same cycle SHALL leave the count unchanged and preserve order.

Reset
REQ-013 On reset, or whenever vdp_super = 0: FIFO emptied, wr_addr = 0, state IDLE, writer_vram_wr = 0, writer_vram_addr = 0, writer_vram_wdata = 0, writer_vram_be = 0, writer_busy = 0, writer_overflow = 0; any outstanding request is abandoned.
REQ-014 CPU writes SHALL be ignored while reset or vdp_super = 0.

Configuration
REQ-015 Macro SUPER_RES_WRITE_COALESCE_EN:
- Defined: at issue, head entry SHALL merge with up to 3 following consecutive entries sharing addr[18:2] and not repeating an already-enabled lane; all merged entries pop together; be/wdata carry each lane.
- Undefined: exactly one byte per VRAM write, be always one-hot.

Verification
REQ-016 addr=0x00004, data 0xAA, drawing low, ack after 3 cycles -> wr high for 4 cycles, addr 0x00001, be 0001, wdata AAAAAAAA; busy low 1 cycle after ack.
REQ-017 addr=0x7FFFF, two data writes 0x11, 0x22 -> writes at word 0x1FFFF be 1000, then word 0x00000 be 0001.
REQ-018 drawing held high, 5 data writes -> 4 queued, 5th dropped, overflow=1, wr low; drawing low -> 4 writes in order; addr-port write clears overflow.
REQ-019 Coalesce on, addr=0x00010, bytes 01 02 03 04 queued under drawing high -> single write addr 0x00004, be 1111, wdata 04030201; coalesce off -> four writes be 0001, 0010, 0100, 1000.
REQ-020 vdp_super dropped in WAIT_ACK with 2 entries queued -> next cycle wr=0, busy=0, FIFO empty; no write after vdp_super returns until new data.

Source files
------------

// File: rtl/vdp_super_res_writer_if.sv
// Bundle of the CPU port inputs and VRAM write-request outputs of the super-res writer.
// The master modport is the driver/VRAM side; the slave modport is the writer itself.
interface vdp_super_res_writer_if;
   logic        vdp_super;
   logic        super_res_drawing;
   logic        cpu_wr;
   logic [1:0]  cpu_port;
   logic [7:0]  cpu_data;
   logic        vram_ack;
   logic [16:0] writer_vram_addr;
   logic [31:0] writer_vram_wdata;
   logic [3:0]  writer_vram_be;
   logic        writer_vram_wr;
   logic        writer_busy;
   logic        writer_overflow;

   modport master (
      output vdp_super, super_res_drawing, cpu_wr, cpu_port, cpu_data, vram_ack,
      input  writer_vram_addr, writer_vram_wdata, writer_vram_be, writer_vram_wr,
             writer_busy, writer_overflow
   );

   modport slave (
      input  vdp_super, super_res_drawing, cpu_wr, cpu_port, cpu_data, vram_ack,
      output writer_vram_addr, writer_vram_wdata, writer_vram_be, writer_vram_wr,
             writer_busy, writer_overflow
   );
endinterface

// File: rtl/vdp_super_res_writer.sv
// CPU-port byte writer into 32-bit VRAM for super-res mode: 4-entry byte FIFO feeding a
// single-outstanding VRAM write request. Define SUPER_RES_WRITE_COALESCE_EN to merge bytes.
module vdp_super_res_writer (
   input  logic                         clk,
   input  logic                         reset,
   vdp_super_res_writer_if.slave        bus
);
   typedef enum logic {IDLE, WAIT_ACK} state_t;
   localparam int DEPTH = 4;

   logic [18:0] fifo_addr_q [DEPTH];
   logic [7:0]  fifo_data_q [DEPTH];
   logic [1:0]  rd_ptr_q, wr_ptr_q;
   logic [2:0]  count_q, count_d;
   logic [18:0] wr_addr_q;
   state_t      state_q, state_d;
   logic [16:0] vaddr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic        wr_q, busy_q, busy_d, ovf_q;

   logic        active, full, push, issue, ovf_set, addr_wr;
   logic [18:0] head_addr;
   logic [7:0]  head_data;
   logic [3:0]  issue_be;
   logic [31:0] issue_wdata;
   logic [2:0]  issue_n;

   assign active    = !reset && bus.vdp_super;
   assign full      = (count_q == 3'(DEPTH));
   assign push      = active && bus.cpu_wr && (bus.cpu_port == 2'd0) && !full;
   assign ovf_set   = bus.cpu_wr && (bus.cpu_port == 2'd0) && full;
   assign addr_wr   = bus.cpu_wr && (bus.cpu_port != 2'd0);
   assign issue     = (state_q == IDLE) && (count_q != 3'd0) && !bus.super_res_drawing;
   assign head_addr = fifo_addr_q[rd_ptr_q];
   assign head_data = fifo_data_q[rd_ptr_q];

`ifdef SUPER_RES_WRITE_COALESCE_EN
   logic [18:0] peek_addr [1:DEPTH-1];
   logic [7:0]  peek_data [1:DEPTH-1];
   logic        merge_ok;

   generate
      for (genvar gi = 1; gi < DEPTH; gi++) begin : g_peek
         assign peek_addr[gi] = fifo_addr_q[rd_ptr_q + 2'(gi)];
         assign peek_data[gi] = fifo_data_q[rd_ptr_q + 2'(gi)];
      end
   endgenerate
`endif

   // Build the request from the head entry; merging stops at the first non-mergeable entry.
   always_comb begin
      issue_be    = 4'b0001 << head_addr[1:0];
      issue_wdata = {4{head_data}};
      issue_n     = 3'd1;
`ifdef SUPER_RES_WRITE_COALESCE_EN
      merge_ok = 1'b1;
      for (int k = 1; k < DEPTH; k++) begin
         if (merge_ok && (3'(k) < count_q) &&
             (peek_addr[k][18:2] == head_addr[18:2]) && !issue_be[peek_addr[k][1:0]]) begin
            issue_be[peek_addr[k][1:0]]             = 1'b1;
            issue_wdata[8*peek_addr[k][1:0] +: 8] = peek_data[k];
            issue_n                                 = issue_n + 3'd1;
         end else begin
            merge_ok = 1'b0;
         end
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (issue) state_d = WAIT_ACK;
         WAIT_ACK: if (bus.vram_ack) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      count_d = count_q + {2'b00, push} - (issue ? issue_n : 3'd0);
      busy_d  = (count_d != 3'd0) || (state_d == WAIT_ACK);
   end

   // Storage carries no reset; emptiness is tracked purely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= wr_addr_q;
         fifo_data_q[wr_ptr_q] <= bus.cpu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!active) begin
         state_q   <= IDLE;
         rd_ptr_q  <= 2'd0;
         wr_ptr_q  <= 2'd0;
         count_q   <= 3'd0;
         wr_addr_q <= 19'd0;
         vaddr_q   <= 17'd0;
         wdata_q   <= 32'd0;
         be_q      <= 4'd0;
         wr_q      <= 1'b0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         if (push) begin
            wr_ptr_q  <= wr_ptr_q + 2'd1;
            wr_addr_q <= wr_addr_q + 19'd1;
         end else if (addr_wr) begin
            case (bus.cpu_port)
               2'd1:    wr_addr_q[7:0]   <= bus.cpu_data;
               2'd2:    wr_addr_q[15:8]  <= bus.cpu_data;
               default: wr_addr_q[18:16] <= bus.cpu_data[2:0];
            endcase
         end
         if (ovf_set) begin
            ovf_q <= 1'b1;
         end else if (addr_wr) begin
            ovf_q <= 1'b0;
         end
         if (issue) begin
            rd_ptr_q <= rd_ptr_q + issue_n[1:0];
            vaddr_q  <= head_addr[18:2];
            be_q     <= issue_be;
            wdata_q  <= issue_wdata;
            wr_q     <= 1'b1;
         end else if ((state_q == WAIT_ACK) && bus.vram_ack) begin
            wr_q <= 1'b0;
         end
      end
   end

   assign bus.writer_vram_addr  = vaddr_q;
   assign bus.writer_vram_wdata = wdata_q;
   assign bus.writer_vram_be    = be_q;
   assign bus.writer_vram_wr    = wr_q;
   assign bus.writer_busy       = busy_q;
   assign bus.writer_overflow   = ovf_q;
endmodule

// File: tb/tb_vdp_super_res_writer.sv
// Self-checking bench for vdp_super_res_writer: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_vdp_super_res_writer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vdp_super_res_writer_if bus();

   vdp_super_res_writer dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [18:0] addr;
      logic [7:0]  data;
      logic [16:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } vec_t;

   typedef struct packed {
      logic [18:0] a;
      logic [7:0]  d;
   } ent_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [1:0] p, input logic [7:0] d);
      bus.cpu_wr   = 1'b1;
      bus.cpu_port = p;
      bus.cpu_data = d;
      step();
      bus.cpu_wr   = 1'b0;
   endtask

   task automatic set_addr(input logic [18:0] a);
      cpu_write(2'd1, a[7:0]);
      cpu_write(2'd2, a[15:8]);
      cpu_write(2'd3, {5'b10101, a[18:16]});
   endtask

   task automatic wait_wr();
      for (int i = 0; i < 20 && !bus.writer_vram_wr; i++) step();
      chk("wr_wait", 32'(bus.writer_vram_wr), 32'd1);
   endtask

   task automatic ack();
      bus.vram_ack = 1'b1;
      step();
      bus.vram_ack = 1'b0;
   endtask

   task automatic chk_req(input string nm, input logic [16:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
      $display("write %s addr=%05h be=%b wdata=%08h", nm, bus.writer_vram_addr,
               bus.writer_vram_be, bus.writer_vram_wdata);
      chk({nm, "_addr"}, 32'(bus.writer_vram_addr), 32'(a));
      chk({nm, "_be"}, 32'(bus.writer_vram_be), 32'(be));
      chk({nm, "_wdata"}, bus.writer_vram_wdata, wd);
   endtask

   vec_t vecs [6];

   ent_t        mq[$];
   logic [18:0] m_wa;
   bit          m_ovf, m_out, prev_wr;
   logic [16:0] m_addr;
   logic [3:0]  m_be;
   logic [31:0] m_wd;

   initial begin
      vecs[0] = '{19'h00004, 8'hAA, 17'h00001, 4'b0001, 32'hAAAAAAAA};
      vecs[1] = '{19'h00005, 8'h5C, 17'h00001, 4'b0010, 32'h5C5C5C5C};
      vecs[2] = '{19'h12346, 8'h3F, 17'h048D1, 4'b0100, 32'h3F3F3F3F};
      vecs[3] = '{19'h7FFFF, 8'h11, 17'h1FFFF, 4'b1000, 32'h11111111};
      vecs[4] = '{19'h40003, 8'hE7, 17'h10000, 4'b1000, 32'hE7E7E7E7};
      vecs[5] = '{19'h00000, 8'h00, 17'h00000, 4'b0001, 32'h00000000};

      reset                 = 1'b1;
      bus.vdp_super         = 1'b1;
      bus.super_res_drawing = 1'b0;
      bus.cpu_wr            = 1'b0;
      bus.cpu_port          = 2'd0;
      bus.cpu_data          = 8'd0;
      bus.vram_ack          = 1'b0;
      // CPU write during reset must be ignored
      cpu_write(2'd0, 8'h99);
      step();
      reset = 1'b0;
      step();
      chk("rst_wr", 32'(bus.writer_vram_wr), 32'd0);
      chk("rst_busy", 32'(bus.writer_busy), 32'd0);
      chk("rst_ovf", 32'(bus.writer_overflow), 32'd0);
      chk("rst_addr", 32'(bus.writer_vram_addr), 32'd0);
      chk("rst_be", 32'(bus.writer_vram_be), 32'd0);
      chk("rst_wdata", bus.writer_vram_wdata, 32'd0);

      // Single-byte writes: latency N+1, 4-cycle hold with drawing rising mid-request
      for (int i = 0; i < 6; i++) begin
         set_addr(vecs[i].addr);
         cpu_write(2'd0, vecs[i].data);
         chk("lat_n", 32'(bus.writer_vram_wr), 32'd0);
         step();
         chk("lat_n1", 32'(bus.writer_vram_wr), 32'd1);
         chk_req($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_be, vecs[i].exp_wdata);
         bus.super_res_drawing = 1'b1;
         step();
         chk("hold_wr", 32'(bus.writer_vram_wr), 32'd1);
         chk("hold_busy", 32'(bus.writer_busy), 32'd1);
         step();
         chk("hold_be", 32'(bus.writer_vram_be), 32'(vecs[i].exp_be));
         ack();
         bus.super_res_drawing = 1'b0;
         chk("ack_wr", 32'(bus.writer_vram_wr), 32'd0);
         chk("ack_busy", 32'(bus.writer_busy), 32'd0);
      end

      // Address wrap 7FFFF -> 00000 and one idle cycle between requests
      set_addr(19'h7FFFF);
      cpu_write(2'd0, 8'h11);
      cpu_write(2'd0, 8'h22);
      chk("wrap_wr1", 32'(bus.writer_vram_wr), 32'd1);
      chk_req("wrap1", 17'h1FFFF, 4'b1000, 32'h11111111);
      ack();
      chk("wrap_idle", 32'(bus.writer_vram_wr), 32'd0);
      chk("wrap_busy", 32'(bus.writer_busy), 32'd1);
      step();
      chk("wrap_wr2", 32'(bus.writer_vram_wr), 32'd1);
      chk_req("wrap2", 17'h00000, 4'b0001, 32'h22222222);
      ack();
      chk("wrap_done", 32'(bus.writer_busy), 32'd0);

      // Overflow under drawing, then drain
      bus.super_res_drawing = 1'b1;
      set_addr(19'h00010);
      for (int k = 0; k < 5; k++) cpu_write(2'd0, 8'(k + 1));
      chk("ovf_set", 32'(bus.writer_overflow), 32'd1);
      chk("ovf_wr", 32'(bus.writer_vram_wr), 32'd0);
      chk("ovf_busy", 32'(bus.writer_busy), 32'd1);
      bus.super_res_drawing = 1'b0;
      step();
`ifdef SUPER_RES_WRITE_COALESCE_EN
      chk("co_wr", 32'(bus.writer_vram_wr), 32'd1);
      chk_req("coalesce", 17'h00004, 4'b1111, 32'h04030201);
      ack();
`else
      for (int j = 0; j < 4; j++) begin
         if (j > 0) begin
            chk("drain_idle", 32'(bus.writer_vram_wr), 32'd0);
            step();
         end
         chk("drain_wr", 32'(bus.writer_vram_wr), 32'd1);
         chk_req($sformatf("drain%0d", j), 17'h00004, 4'(4'b0001 << j), {4{8'(j + 1)}});
         ack();
      end
`endif
      chk("drain_busy", 32'(bus.writer_busy), 32'd0);
      chk("ovf_sticky", 32'(bus.writer_overflow), 32'd1);
      cpu_write(2'd1, 8'h00);
      chk("ovf_clr", 32'(bus.writer_overflow), 32'd0);

      // vdp_super dropped while a request is outstanding with two entries queued
      set_addr(19'h00200);
      cpu_write(2'd0, 8'hA1);
      set_addr(19'h00300);
      cpu_write(2'd0, 8'hB2);
      set_addr(19'h00400);
      cpu_write(2'd0, 8'hC3);
      chk("sup_wr", 32'(bus.writer_vram_wr), 32'd1);
      chk("sup_busy", 32'(bus.writer_busy), 32'd1);
      bus.vdp_super = 1'b0;
      step();
      chk("sup_off_wr", 32'(bus.writer_vram_wr), 32'd0);
      chk("sup_off_busy", 32'(bus.writer_busy), 32'd0);
      chk("sup_off_addr", 32'(bus.writer_vram_addr), 32'd0);
      chk("sup_off_be", 32'(bus.writer_vram_be), 32'd0);
      chk("sup_off_wdata", bus.writer_vram_wdata, 32'd0);
      bus.vdp_super = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("sup_quiet_wr", 32'(bus.writer_vram_wr), 32'd0);
         chk("sup_quiet_busy", 32'(bus.writer_busy), 32'd0);
      end
      cpu_write(2'd0, 8'h77);
      step();
      chk("sup_new_wr", 32'(bus.writer_vram_wr), 32'd1);
      chk_req("sup_new", 17'h00000, 4'b0001, 32'h77777777);
      ack();

      // Randomized traffic against the queue model
      bus.vdp_super = 1'b0;
      step();
      bus.vdp_super = 1'b1;
      mq.delete();
      m_wa    = 19'd0;
      m_ovf   = 1'b0;
      m_out   = 1'b0;
      prev_wr = 1'b0;
      m_addr  = 17'd0;
      m_be    = 4'd0;
      m_wd    = 32'd0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit          w, dr, ak, sup, exp_issue, rising, idle_pre;
         logic [1:0]  p;
         logic [7:0]  dd;
         int          qpre;
         ent_t        e;
         w   = ($urandom % 2) == 0;
         p   = (($urandom % 5) < 3) ? 2'd0 : 2'($urandom_range(1, 3));
         dd  = 8'($urandom);
         dr  = ($urandom % 10) < 3;
         ak  = m_out && (($urandom % 3) == 0);
         sup = ($urandom % 250) != 0;
         bus.cpu_wr            = w;
         bus.cpu_port          = p;
         bus.cpu_data          = dd;
         bus.super_res_drawing = dr;
         bus.vram_ack          = ak;
         bus.vdp_super         = sup;
         qpre     = mq.size();
         idle_pre = !m_out;
         step();
         exp_issue = 1'b0;
         if (!sup) begin
            mq.delete();
            m_wa  = 19'd0;
            m_ovf = 1'b0;
            m_out = 1'b0;
         end else begin
            if (w) begin
               case (p)
                  2'd0: if (mq.size() < 4) begin
                           mq.push_back({m_wa, dd});
                           m_wa = m_wa + 19'd1;
                        end else m_ovf = 1'b1;
                  2'd1: begin m_wa[7:0] = dd; m_ovf = 1'b0; end
                  2'd2: begin m_wa[15:8] = dd; m_ovf = 1'b0; end
                  default: begin m_wa[18:16] = dd[2:0]; m_ovf = 1'b0; end
               endcase
            end
            if (m_out && ak) m_out = 1'b0;
            exp_issue = idle_pre && (qpre > 0) && !dr;
         end
         rising = bus.writer_vram_wr && !prev_wr;
         chk("rnd_issue", 32'(rising), 32'(exp_issue));
         if (exp_issue && rising) begin
            e      = mq.pop_front();
            m_addr = e.a[18:2];
            m_be   = 4'b0001 << e.a[1:0];
            m_wd   = {4{e.d}};
`ifdef SUPER_RES_WRITE_COALESCE_EN
            for (int n = 1; n < qpre && mq.size() > 0; n++) begin
               if (mq[0].a[18:2] != m_addr || m_be[mq[0].a[1:0]]) break;
               m_be[mq[0].a[1:0]]           = 1'b1;
               m_wd[8*mq[0].a[1:0] +: 8] = mq[0].d;
               void'(mq.pop_front());
            end
`endif
            m_out = 1'b1;
            chk_req($sformatf("rnd%0d", cyc), m_addr, m_be, m_wd);
         end else if (m_out) begin
            chk("rnd_hold_addr", 32'(bus.writer_vram_addr), 32'(m_addr));
            chk("rnd_hold_be", 32'(bus.writer_vram_be), 32'(m_be));
            chk("rnd_hold_wdata", bus.writer_vram_wdata, m_wd);
         end
         chk("rnd_wr", 32'(bus.writer_vram_wr), 32'(m_out));
         chk("rnd_busy", 32'(bus.writer_busy), 32'((mq.size() > 0) || m_out));
         chk("rnd_ovf", 32'(bus.writer_overflow), 32'(m_ovf));
         prev_wr = bus.writer_vram_wr;
      end
      bus.cpu_wr   = 1'b0;
      bus.vram_ack = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
